// File: rtl/enemy_pkg.sv
// Shared constants, FSM/sweep types and the spawn LFSR step for the enemy datapath.
// The optional zigzag motion (ENEMY_ZIGZAG_EN) lives entirely in enemy_datapath.
`timescale 1ns/1ps
package enemy_pkg;

  localparam int         SCREEN_W_DEF     = 160;
  localparam int         SCREEN_H_DEF     = 120;
  localparam int         SPRITE_DEF       = 4;
  localparam int         FRAME_DIV_DEF    = 833333;
  localparam int         STEP_DEF         = 1;
  localparam logic [2:0] ENEMY_COLOUR_DEF = 3'b100;
  localparam logic [2:0] BG_COLOUR_DEF    = 3'b000;
  localparam logic [7:0] LFSR_SEED        = 8'h01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    MOVE  = 3'd2,
    DRAW  = 3'd3,
    HIDE  = 3'd4
  } enemy_state_e;

  typedef enum logic {
    PATH_SPAWN = 1'b0,
    PATH_MOVE  = 1'b1
  } sweep_path_e;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/sprite_pixel_iter.sv
// Row-major (dx fastest) pixel walker over a SPRITE x SPRITE box.
// start arms it at (0,0); each enabled cycle advances one pixel; last marks the final one.
`timescale 1ns/1ps
module sprite_pixel_iter
  import enemy_pkg::*;
#(
  parameter  int SPRITE = SPRITE_DEF,
  localparam int DW     = (SPRITE > 1) ? $clog2(SPRITE) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          enable,
  output logic [DW-1:0] dx,
  output logic [DW-1:0] dy,
  output logic          last,
  output logic          active
);

  localparam logic [DW-1:0] MAXC = DW'(SPRITE - 1);

  logic [DW-1:0] dx_q, dx_d;
  logic [DW-1:0] dy_q, dy_d;
  logic          active_q, active_d;

  assign dx     = dx_q;
  assign dy     = dy_q;
  assign active = active_q;
  assign last   = active_q && (dx_q == MAXC) && (dy_q == MAXC);

  // Next pixel position; start has priority over advancing.
  always_comb begin
    dx_d     = dx_q;
    dy_d     = dy_q;
    active_d = active_q;
    if (start) begin
      dx_d     = '0;
      dy_d     = '0;
      active_d = 1'b1;
    end else if (enable && active_q) begin
      if (dx_q == MAXC) begin
        dx_d = '0;
        if (dy_q == MAXC) begin
          dy_d     = '0;
          active_d = 1'b0;
        end else begin
          dy_d = dy_q + 1'b1;
        end
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Iterator state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx_q     <= '0;
      dy_q     <= '0;
      active_q <= 1'b0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/enemy_datapath.sv
// Enemy datapath: frame tick, position registers, status flags and erase/redraw sequencer.
// Define ENEMY_ZIGZAG_EN to add horizontal zigzag motion on every move.
`timescale 1ns/1ps
module enemy_datapath
  import enemy_pkg::*;
#(
  parameter int         SCREEN_W     = SCREEN_W_DEF,
  parameter int         SCREEN_H     = SCREEN_H_DEF,
  parameter int         SPRITE       = SPRITE_DEF,
  parameter int         FRAME_DIV    = FRAME_DIV_DEF,
  parameter int         STEP         = STEP_DEF,
  parameter logic [2:0] ENEMY_COLOUR = ENEMY_COLOUR_DEF,
  parameter logic [2:0] BG_COLOUR    = BG_COLOUR_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_reset_state,
  input  logic       in_update_position_state,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic       update_position,
  output logic       bottom_reached,
  output logic       collided_with_bullet,
  output logic       collided_with_player,
  output logic [7:0] enemy_x,
  output logic [6:0] enemy_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy
);

  localparam int         DW     = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam int         CW     = $clog2(FRAME_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(FRAME_DIV - 1);
  localparam logic [7:0] X_MAX  = 8'(SCREEN_W - SPRITE);
  localparam logic [7:0] X_WRAP = 8'(SCREEN_W - SPRITE + 1);
  localparam logic [7:0] Y_MAX  = 8'(SCREEN_H - SPRITE);

  enemy_state_e  state_q, state_d;
  sweep_path_e   path_q, path_d;
  logic [7:0]    ex_q, ex_d;
  logic [6:0]    ey_q, ey_d;
  logic          visible_q, visible_d;
  logic          pending_q, pending_d;
  logic          tick_req_q, tick_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q;
`ifdef ENEMY_ZIGZAG_EN
  logic          dir_q, dir_d;
`endif

  logic [7:0]    spawn_x_s;
  logic [7:0]    ny_s;
  logic          upd_pulse_s;
  logic          iter_start_s, iter_en_s;
  logic [DW-1:0] dx_s, dy_s;
  logic          iter_last_s, iter_active_s;

  sprite_pixel_iter #(.SPRITE(SPRITE)) u_iter (
    .clk    (clk),
    .resetn (resetn),
    .start  (iter_start_s),
    .enable (iter_en_s),
    .dx     (dx_s),
    .dy     (dy_s),
    .last   (iter_last_s),
    .active (iter_active_s)
  );

  assign spawn_x_s   = (lfsr_q <= X_MAX) ? lfsr_q : (lfsr_q - X_WRAP);
  assign ny_s        = {1'b0, ey_q} + 8'(STEP);
  assign upd_pulse_s = tick_req_q && (state_q == IDLE) && !in_reset_state;
  assign iter_en_s   = (state_q == ERASE) || (state_q == DRAW);

  // Frame divider; a tick that lands while busy waits in tick_req and later ticks merge.
  always_comb begin
    if (cnt_q == '0) begin
      cnt_d      = RELOAD;
      tick_req_d = 1'b1;
    end else begin
      cnt_d      = cnt_q - 1'b1;
      tick_req_d = upd_pulse_s ? 1'b0 : tick_req_q;
    end
  end

  // Sequencer next state and position updates.
  always_comb begin
    state_d      = state_q;
    path_d       = path_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    visible_d    = visible_q;
    pending_d    = pending_q;
    iter_start_s = 1'b0;
`ifdef ENEMY_ZIGZAG_EN
    dir_d        = dir_q;
`endif
    if ((state_q != IDLE) && in_update_position_state) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      IDLE: begin
        if (in_reset_state) begin
          pending_d = 1'b0;
          if (visible_q) begin
            state_d = ERASE;
            path_d  = PATH_SPAWN;
          end else begin
            ex_d = spawn_x_s;
            ey_d = 7'd0;
`ifdef ENEMY_ZIGZAG_EN
            dir_d = lfsr_q[0];
`endif
          end
        end else if (in_update_position_state || pending_q) begin
          pending_d = 1'b0;
          path_d    = PATH_MOVE;
          state_d   = visible_q ? ERASE : MOVE;
        end else begin
          state_d = IDLE;
        end
      end
      // The first ERASE cycle arms the iterator; MOVE arms it for DRAW.
      ERASE: begin
        if (!iter_active_s) begin
          iter_start_s = 1'b1;
        end else if (iter_last_s) begin
          state_d = (path_q == PATH_MOVE) ? MOVE : HIDE;
        end else begin
          state_d = ERASE;
        end
      end
      MOVE: begin
        ey_d = (ny_s > Y_MAX) ? Y_MAX[6:0] : ny_s[6:0];
`ifdef ENEMY_ZIGZAG_EN
        if (!dir_q) begin
          if (ex_q >= X_MAX) begin
            dir_d = 1'b1;
          end else begin
            ex_d = ex_q + 8'd1;
          end
        end else begin
          if (ex_q == 8'd0) begin
            dir_d = 1'b0;
          end else begin
            ex_d = ex_q - 8'd1;
          end
        end
`endif
        iter_start_s = 1'b1;
        state_d      = DRAW;
      end
      DRAW: begin
        if (iter_last_s) begin
          visible_d = 1'b1;
          state_d   = IDLE;
        end else if (!iter_active_s) begin
          iter_start_s = 1'b1;
        end else begin
          state_d = DRAW;
        end
      end
      HIDE: begin
        ex_d      = spawn_x_s;
        ey_d      = 7'd0;
        visible_d = 1'b0;
`ifdef ENEMY_ZIGZAG_EN
        dir_d     = lfsr_q[0];
`endif
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Plot port driven straight from the sequencer and iterator registers.
  always_comb begin
    plot       = iter_active_s && iter_en_s;
    vga_colour = (state_q == DRAW) ? ENEMY_COLOUR : BG_COLOUR;
    if (plot) begin
      vga_x = ex_q + 8'(dx_s);
      vga_y = ey_q + 7'(dy_s);
    end else begin
      vga_x = 8'd0;
      vga_y = 7'd0;
    end
  end

  logic [8:0] ex9, ey9, bx9, by9, px9, py9, xdist, ydist;
  assign ex9   = {1'b0, ex_q};
  assign ey9   = {2'b00, ey_q};
  assign bx9   = {1'b0, bullet_x};
  assign by9   = {2'b00, bullet_y};
  assign px9   = {1'b0, player_x};
  assign py9   = {2'b00, player_y};
  assign xdist = (ex9 >= px9) ? (ex9 - px9) : (px9 - ex9);
  assign ydist = (ey9 >= py9) ? (ey9 - py9) : (py9 - ey9);

  assign bottom_reached       = visible_q && ({1'b0, ey_q} >= Y_MAX);
  assign collided_with_bullet = visible_q && bullet_active &&
                                (bx9 >= ex9) && (bx9 <= ex9 + 9'(SPRITE - 1)) &&
                                (by9 >= ey9) && (by9 <= ey9 + 9'(SPRITE - 1));
  assign collided_with_player = visible_q && (xdist < 9'(SPRITE)) && (ydist < 9'(SPRITE));

  assign update_position = upd_pulse_s;
  assign busy            = (state_q != IDLE);
  assign enemy_x         = ex_q;
  assign enemy_y         = ey_q;

  // Datapath and sequencer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      path_q     <= PATH_MOVE;
      ex_q       <= 8'd0;
      ey_q       <= 7'd0;
      visible_q  <= 1'b0;
      pending_q  <= 1'b0;
      tick_req_q <= 1'b0;
      cnt_q      <= RELOAD;
      lfsr_q     <= LFSR_SEED;
`ifdef ENEMY_ZIGZAG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      path_q     <= path_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      visible_q  <= visible_d;
      pending_q  <= pending_d;
      tick_req_q <= tick_req_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_next(lfsr_q);
`ifdef ENEMY_ZIGZAG_EN
      dir_q      <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_enemy_datapath.sv
// Scoreboard bench for enemy_datapath: stimulus pushes expected plots, a monitor pops them.
`timescale 1ns/1ps
module tb_enemy_datapath;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_reset_state = 1'b0;
  logic       in_upd = 1'b0;
  logic [7:0] bullet_x = 8'd0;
  logic [6:0] bullet_y = 7'd0;
  logic       bullet_active = 1'b0;
  logic [7:0] player_x = 8'd0;
  logic [6:0] player_y = 7'd0;
  logic       update_position, bottom_reached, collided_with_bullet, collided_with_player;
  logic [7:0] enemy_x, vga_x;
  logic [6:0] enemy_y, vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy;

  enemy_datapath #(.FRAME_DIV(10)) dut (
    .clk(clk), .resetn(resetn), .in_reset_state(in_reset_state),
    .in_update_position_state(in_upd),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .player_x(player_x), .player_y(player_y),
    .update_position(update_position), .bottom_reached(bottom_reached),
    .collided_with_bullet(collided_with_bullet), .collided_with_player(collided_with_player),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         busy_cnt = 0;
  logic [7:0] m_lfsr;
  int         mx = 0;
  int         my = 0;
  bit         mvis = 1'b0;

  // Reference spawn LFSR (taps 8,6,5,4, seed 1), used only to time the spawn release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'h01;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge clk) if (busy) busy_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plot monitor: every plot must match the next expected pixel.
  always @(negedge clk) begin
    pix_t e;
    if (resetn && plot) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        check("plot_x", vga_x, e.x);
        check("plot_y", vga_y, e.y);
        check("plot_colour", vga_colour, e.c);
      end
    end
  end

  function automatic int spawn_of(input logic [7:0] l);
    return (l <= 8'd156) ? int'(l) : int'(l) - 157;
  endfunction

  task automatic push_sweep(input int x, input int y, input logic [2:0] c);
    pix_t p;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        p.x = 8'(x + dx);
        p.y = 7'(y + dy);
        p.c = c;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic model_update();
    if (mvis) push_sweep(mx, my, 3'b000);
    my = (my + 1 > 116) ? 116 : my + 1;
    push_sweep(mx, my, 3'b100);
    mvis = 1'b1;
  endtask

  task automatic pulse_update();
    @(negedge clk);
    in_upd = 1'b1;
    model_update();
    @(negedge clk);
    in_upd = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_update();
    int n;
    int exp_busy;
    exp_busy = mvis ? 34 : 17;
    pulse_update();
    wait_idle(n);
    check("busy_cycles", n, exp_busy);
  endtask

  task automatic spawn_at(input int target);
    int n;
    int cnt;
    @(negedge clk);
    in_reset_state = 1'b1;
    if (mvis) push_sweep(mx, my, 3'b000);
    @(negedge clk);
    wait_idle(n);
    check("spawn_busy", n, mvis ? 18 : 0);
    mvis = 1'b0;
    my   = 0;
    cnt  = 0;
    while (spawn_of(m_lfsr) != target && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    in_reset_state = 1'b0;
    mx = target;
    #1;
    check("spawn_x", enemy_x, target);
    check("spawn_y", enemy_y, 0);
    check("spawn_hidden_bottom", bottom_reached, 0);
  endtask

  task automatic set_obj(input int bx, input int by, input bit ba, input int px, input int py);
    bullet_x = 8'(bx);
    bullet_y = 7'(by);
    bullet_active = ba;
    player_x = 8'(px);
    player_y = 7'(py);
    #1;
  endtask

  initial begin
    int first;
    int second;
    int highs;
    int b0;
    #23;
    check("rst_update_position", update_position, 0);
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_enemy_x", enemy_x, 0);
    check("rst_enemy_y", enemy_y, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_vga_colour", vga_colour, 0);
    check("rst_bottom", bottom_reached, 0);
    check("rst_coll_bullet", collided_with_bullet, 0);
    check("rst_coll_player", collided_with_player, 0);

    @(negedge clk);
    resetn = 1'b1;
    first = -1; second = -1; highs = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (update_position) begin
        highs++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("tick_first", first, 10);
    check("tick_second", second, 20);
    check("tick_pulses", highs, 2);

    spawn_at(20);
    while (my < 30) do_update();
    check("pos_x_20", enemy_x, 20);
    check("pos_y_30", enemy_y, 30);
    do_update();
    check("pos_y_31", enemy_y, 31);

    spawn_at(50);
    while (my < 40) do_update();
    check("pos_y_40", enemy_y, 40);
    check("bottom_mid", bottom_reached, 0);

    set_obj(53, 43, 1'b1, 0, 0);  check("bullet_corner", collided_with_bullet, 1);
    set_obj(54, 43, 1'b1, 0, 0);  check("bullet_right_out", collided_with_bullet, 0);
    set_obj(53, 44, 1'b1, 0, 0);  check("bullet_below_out", collided_with_bullet, 0);
    set_obj(53, 43, 1'b0, 0, 0);  check("bullet_inactive", collided_with_bullet, 0);
    set_obj(50, 40, 1'b1, 0, 0);  check("bullet_origin", collided_with_bullet, 1);
    set_obj(49, 40, 1'b1, 0, 0);  check("bullet_left_out", collided_with_bullet, 0);
    set_obj(0, 0, 1'b0, 47, 37);  check("player_overlap_ul", collided_with_player, 1);
    set_obj(0, 0, 1'b0, 46, 40);  check("player_left_out", collided_with_player, 0);
    set_obj(0, 0, 1'b0, 53, 43);  check("player_overlap_lr", collided_with_player, 1);
    set_obj(0, 0, 1'b0, 50, 44);  check("player_below_out", collided_with_player, 0);
    set_obj(0, 0, 1'b0, 0, 0);

    b0 = busy_cnt;
    pulse_update();
    repeat (22) @(negedge clk);
    pulse_update();
    repeat (120) @(negedge clk);
    check("pending_busy_total", busy_cnt - b0, 68);
    check("pending_y", enemy_y, 42);
    check("pending_queue_empty", exp_q.size(), 0);

    while (my < 115) do_update();
    check("bottom_at_115", bottom_reached, 0);
    do_update();
    check("pos_y_116", enemy_y, 116);
    check("bottom_at_116", bottom_reached, 1);
    do_update();
    check("pos_y_saturate", enemy_y, 116);
    check("bottom_saturate", bottom_reached, 1);
    check("queue_empty", exp_q.size(), 0);

    pulse_update();
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    check("abort_enemy_y", enemy_y, 0);
    check("abort_colour", vga_colour, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
